// File: rtl/itim_cache.sv
// Direct-mapped instruction cache between fetch and the backing instruction memory.
// Hits return in one cycle; misses refill a whole line word by word; fence.i walks the valid bits.
module itim_cache #(
    parameter int ITIM_WIDTH = 2,
    parameter int ITIM_DEPTH = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        itim_valid,
    input  logic [31:0] itim_addr,
    input  logic        itim_inv,
    output logic        itim_ready,
    output logic [31:0] itim_rdata,
    output logic        itim_busy,
    output logic        imem_valid,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata
);

    localparam int TAG_W = 30 - ITIM_WIDTH - ITIM_DEPTH;
    localparam int LINES = 1 << ITIM_DEPTH;
    localparam int WORDS = 1 << ITIM_WIDTH;
    localparam int IDX_LO = ITIM_WIDTH + 2;
    localparam int TAG_LO = ITIM_WIDTH + ITIM_DEPTH + 2;

    typedef enum logic [1:0] {
        HIT,
        MISS,
        LOAD,
        INV
    } state_t;

    state_t                  state_q;
    logic [ITIM_DEPTH-1:0]   walk_q;
    logic [ITIM_WIDTH-1:0]   word_q;
    logic                    pending_q;
    logic                    inv_pend_q;
    logic [31:2]             addr_q;
    logic                    ready_q;
    logic [31:0]             rdata_q;
    logic                    imem_valid_q;
    logic [31:0]             imem_addr_q;
    logic [LINES-1:0]        valid_q;

    logic [TAG_W-1:0]        tag_mem  [LINES];
    logic [31:0]             data_mem [LINES*WORDS];

    logic [31:2]             req_addr;
    logic                    req_vld;
    logic [ITIM_WIDTH-1:0]   req_word;
    logic [ITIM_DEPTH-1:0]   req_idx;
    logic [TAG_W-1:0]        req_tag;
    logic                    req_hit;
    logic [ITIM_DEPTH-1:0]   a_idx;
    logic [TAG_W-1:0]        a_tag;
    logic                    fill_we;
    logic                    unused_addr_bits;

    assign unused_addr_bits = ^itim_addr[1:0];

    // A held fetch takes precedence over the live port; the live port is only
    // looked at when nothing is outstanding, which gives the one-cycle hit path.
    assign req_addr = pending_q ? addr_q : itim_addr[31:2];
    assign req_vld  = pending_q | itim_valid;
    assign req_word = req_addr[IDX_LO-1:2];
    assign req_idx  = req_addr[TAG_LO-1:IDX_LO];
    assign req_tag  = req_addr[31:TAG_LO];
    assign req_hit  = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    assign a_idx    = addr_q[TAG_LO-1:IDX_LO];
    assign a_tag    = addr_q[31:TAG_LO];
    assign fill_we  = !rst && (state_q == LOAD) && imem_ready;

    always_ff @(posedge clk) begin
        if (fill_we) begin
            data_mem[{a_idx, word_q}] <= imem_rdata;
            if (&word_q) begin
                tag_mem[a_idx] <= a_tag;
            end
        end
    end

    // Valid bits are not reset: reset starts an invalidate walk that clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INV;
            walk_q       <= '0;
            word_q       <= '0;
            pending_q    <= 1'b0;
            inv_pend_q   <= 1'b0;
            addr_q       <= '0;
            ready_q      <= 1'b0;
            rdata_q      <= '0;
            imem_valid_q <= 1'b0;
            imem_addr_q  <= '0;
        end else begin
            ready_q      <= 1'b0;
            imem_valid_q <= 1'b0;
            if (itim_valid && !pending_q) begin
                addr_q    <= itim_addr[31:2];
                pending_q <= 1'b1;
            end
            case (state_q)
                HIT: begin
                    if (itim_inv) begin
                        state_q <= INV;
                        walk_q  <= '0;
                    end else if (req_vld) begin
                        if (req_hit) begin
                            ready_q   <= 1'b1;
                            rdata_q   <= data_mem[{req_idx, req_word}];
                            pending_q <= 1'b0;
                        end else begin
                            state_q <= MISS;
                            word_q  <= '0;
                        end
                    end
                end
                MISS: begin
                    imem_valid_q <= 1'b1;
                    imem_addr_q  <= {a_tag, a_idx, word_q, 2'b00};
                    state_q      <= LOAD;
                    if (itim_inv) begin
                        inv_pend_q <= 1'b1;
                    end
                end
                LOAD: begin
                    if (itim_inv) begin
                        inv_pend_q <= 1'b1;
                    end
                    if (imem_ready) begin
                        if (&word_q) begin
                            valid_q[a_idx] <= 1'b1;
                            if (inv_pend_q || itim_inv) begin
                                state_q    <= INV;
                                walk_q     <= '0;
                                inv_pend_q <= 1'b0;
                            end else begin
                                state_q <= HIT;
                            end
                        end else begin
                            word_q  <= word_q + {{(ITIM_WIDTH-1){1'b0}}, 1'b1};
                            state_q <= MISS;
                        end
                    end
                end
                INV: begin
                    valid_q[walk_q] <= 1'b0;
                    if (itim_inv) begin
                        walk_q <= '0;
                    end else if (&walk_q) begin
                        state_q <= HIT;
                    end else begin
                        walk_q <= walk_q + {{(ITIM_DEPTH-1){1'b0}}, 1'b1};
                    end
                end
                default: state_q <= INV;
            endcase
        end
    end

    assign itim_ready = ready_q;
    assign itim_rdata = rdata_q;
    assign itim_busy  = (state_q != HIT);
    assign imem_valid = imem_valid_q;
    assign imem_addr  = imem_addr_q;

endmodule

// File: tb/tb_itim_cache.sv
// Directed bench for itim_cache (W=2, D=6) with a fixed-latency backing memory responder.
module tb_itim_cache;

    logic        clk;
    logic        rst;
    logic        itim_valid;
    logic [31:0] itim_addr;
    logic        itim_inv;
    logic        itim_ready;
    logic [31:0] itim_rdata;
    logic        itim_busy;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    int compared = 0;
    int mismatched = 0;

    int          gReadyAt;
    int          gFirstImemAt;
    int          gImemCnt;
    logic [31:0] gRdata;
    logic [31:0] gImemAddr [8];

    itim_cache #(.ITIM_WIDTH(2), .ITIM_DEPTH(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .itim_valid (itim_valid),
        .itim_addr  (itim_addr),
        .itim_inv   (itim_inv),
        .itim_ready (itim_ready),
        .itim_rdata (itim_rdata),
        .itim_busy  (itim_busy),
        .imem_valid (imem_valid),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a[31:4] == 28'h0000010) return 32'h0000_00A0 + {28'h0, 2'b00, a[3:2]};
        return 32'hC0DE_0000 | a;
    endfunction

    // Backing memory: answers each read request one cycle after seeing it, for one cycle.
    logic        armed;
    logic [31:0] armAddr;
    initial begin
        imem_ready = 1'b0;
        imem_rdata = '0;
        armed = 1'b0;
        armAddr = '0;
        forever begin
            @(negedge clk);
            if (imem_ready) imem_ready = 1'b0;
            if (armed) begin
                imem_ready = 1'b1;
                imem_rdata = memWord(armAddr);
                armed = 1'b0;
            end
            if (imem_valid) begin
                armed = 1'b1;
                armAddr = imem_addr;
            end
        end
    end

    // Issue one fetch at the current negedge and follow it to itim_ready or the cycle budget.
    task automatic runFetch(input logic [31:0] a, input logic withInv, input int maxCyc);
        gImemCnt = 0;
        gReadyAt = -1;
        gFirstImemAt = -1;
        gRdata = '0;
        itim_valid = 1'b1;
        itim_addr = a;
        itim_inv = withInv;
        for (int n = 1; n <= maxCyc; n++) begin
            @(negedge clk);
            if (n == 1) begin
                itim_valid = 1'b0;
                itim_inv = 1'b0;
            end
            if (imem_valid) begin
                if (gImemCnt < 8) gImemAddr[gImemCnt] = imem_addr;
                if (gFirstImemAt < 0) gFirstImemAt = n;
                gImemCnt++;
            end
            if (itim_ready) begin
                gReadyAt = n;
                gRdata = itim_rdata;
                break;
            end
        end
    endtask

    task automatic countBusy(output int n, output int bad);
        n = 0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            if (!itim_busy) break;
            n++;
            if (imem_valid || itim_ready) bad++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        int n, bad;
        rst = 1'b1;
        itim_valid = 1'b0;
        itim_addr = '0;
        itim_inv = 1'b0;
        @(negedge clk);
        compared++; if (itim_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ready got %0b want 0", itim_ready); end
        compared++; if (itim_rdata !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_rdata got %h want 0", itim_rdata); end
        compared++; if (imem_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_imem_valid got %0b want 0", imem_valid); end
        compared++; if (imem_addr !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_imem_addr got %h want 0", imem_addr); end
        compared++; if (itim_busy !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_busy got %0b want 1", itim_busy); end
        rst = 1'b0;
        countBusy(n, bad);
        compared++; if (n !== 64) begin mismatched++; $display("[TB] FAIL reset_walk_len got %0d want 64", n); end
        compared++; if (bad !== 0) begin mismatched++; $display("[TB] FAIL reset_walk_quiet got %0d want 0", bad); end
    endtask

    task automatic test_miss_refill;
        runFetch(32'h0000_0104, 1'b0, 40);
        compared++; if (gImemCnt !== 4) begin mismatched++; $display("[TB] FAIL miss_pulses got %0d want 4", gImemCnt); end
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (gImemAddr[i] !== 32'h100 + 32'(i * 4)) begin
                mismatched++; $display("[TB] FAIL miss_addr%0d got %h want %h", i, gImemAddr[i], 32'h100 + 32'(i * 4));
            end
        end
        compared++; if (gFirstImemAt !== 2) begin mismatched++; $display("[TB] FAIL miss_first_req got %0d want 2", gFirstImemAt); end
        compared++; if (gReadyAt !== 14) begin mismatched++; $display("[TB] FAIL miss_latency got %0d want 14", gReadyAt); end
        compared++; if (gRdata !== 32'hA1) begin mismatched++; $display("[TB] FAIL miss_rdata got %h want 000000a1", gRdata); end
    endtask

    task automatic test_hit;
        runFetch(32'h0000_010C, 1'b0, 40);
        compared++; if (gReadyAt !== 1) begin mismatched++; $display("[TB] FAIL hit_latency got %0d want 1", gReadyAt); end
        compared++; if (gRdata !== 32'hA3) begin mismatched++; $display("[TB] FAIL hit_rdata got %h want 000000a3", gRdata); end
        compared++; if (gImemCnt !== 0) begin mismatched++; $display("[TB] FAIL hit_no_imem got %0d want 0", gImemCnt); end
    endtask

    task automatic test_back_to_back;
        runFetch(32'h0000_0108, 1'b0, 40);
        compared++; if (gReadyAt !== 1 || gRdata !== 32'hA2) begin mismatched++; $display("[TB] FAIL b2b_first got %0d/%h want 1/000000a2", gReadyAt, gRdata); end
        runFetch(32'h0000_0100, 1'b0, 40);
        compared++; if (gReadyAt !== 1 || gRdata !== 32'hA0) begin mismatched++; $display("[TB] FAIL b2b_second got %0d/%h want 1/000000a0", gReadyAt, gRdata); end
    endtask

    task automatic test_eviction;
        runFetch(32'h0000_0500, 1'b0, 40);
        compared++; if (gImemCnt !== 4 || gImemAddr[0] !== 32'h500 || gImemAddr[3] !== 32'h50C) begin
            mismatched++; $display("[TB] FAIL evict_refill got %0d %h..%h want 4 00000500..0000050c", gImemCnt, gImemAddr[0], gImemAddr[3]);
        end
        compared++; if (gRdata !== 32'hC0DE_0500) begin mismatched++; $display("[TB] FAIL evict_rdata got %h want c0de0500", gRdata); end
        runFetch(32'h0000_0100, 1'b0, 40);
        compared++; if (gImemCnt !== 4 || gImemAddr[0] !== 32'h100) begin mismatched++; $display("[TB] FAIL evict_remiss got %0d %h want 4 00000100", gImemCnt, gImemAddr[0]); end
        compared++; if (gRdata !== 32'hA0) begin mismatched++; $display("[TB] FAIL evict_rdata2 got %h want 000000a0", gRdata); end
    endtask

    task automatic test_inv_with_fetch;
        runFetch(32'h0000_0104, 1'b1, 120);
        compared++; if (gFirstImemAt !== 67) begin mismatched++; $display("[TB] FAIL invf_first_req got %0d want 67", gFirstImemAt); end
        compared++; if (gImemCnt !== 4) begin mismatched++; $display("[TB] FAIL invf_pulses got %0d want 4", gImemCnt); end
        compared++; if (gReadyAt !== 79) begin mismatched++; $display("[TB] FAIL invf_latency got %0d want 79", gReadyAt); end
        compared++; if (gRdata !== 32'hA1) begin mismatched++; $display("[TB] FAIL invf_rdata got %h want 000000a1", gRdata); end
    endtask

    task automatic test_inv_restart;
        int n, bad;
        itim_inv = 1'b1;
        @(negedge clk);
        itim_inv = 1'b0;
        repeat (9) @(negedge clk);
        compared++; if (itim_busy !== 1'b1) begin mismatched++; $display("[TB] FAIL restart_busy got %0b want 1", itim_busy); end
        itim_inv = 1'b1;
        @(negedge clk);
        itim_inv = 1'b0;
        countBusy(n, bad);
        compared++; if (n !== 64) begin mismatched++; $display("[TB] FAIL restart_walk_len got %0d want 64", n); end
        runFetch(32'h0000_0100, 1'b0, 40);
        compared++; if (gImemCnt !== 4 || gRdata !== 32'hA0) begin mismatched++; $display("[TB] FAIL restart_refetch got %0d/%h want 4/000000a0", gImemCnt, gRdata); end
    endtask

    task automatic test_reset_mid_refill;
        int seen, n, bad;
        logic [31:0] lastAddr;
        seen = 0;
        lastAddr = '0;
        itim_valid = 1'b1;
        itim_addr = 32'h0000_0908;
        for (int i = 0; i < 40 && seen < 3; i++) begin
            @(negedge clk);
            itim_valid = 1'b0;
            if (imem_valid) begin
                seen++;
                lastAddr = imem_addr;
            end
        end
        compared++; if (seen !== 3 || lastAddr !== 32'h908) begin mismatched++; $display("[TB] FAIL rstmid_word2 got %0d/%h want 3/00000908", seen, lastAddr); end
        rst = 1'b1;
        @(negedge clk);
        compared++; if (imem_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_imem_valid got %0b want 0", imem_valid); end
        compared++; if (itim_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL rstmid_ready got %0b want 0", itim_ready); end
        rst = 1'b0;
        countBusy(n, bad);
        compared++; if (n !== 64) begin mismatched++; $display("[TB] FAIL rstmid_walk_len got %0d want 64", n); end
        compared++; if (bad !== 0) begin mismatched++; $display("[TB] FAIL rstmid_quiet got %0d want 0", bad); end
        runFetch(32'h0000_0104, 1'b0, 40);
        compared++; if (gImemCnt !== 4 || gImemAddr[0] !== 32'h100) begin mismatched++; $display("[TB] FAIL rstmid_remiss got %0d %h want 4 00000100", gImemCnt, gImemAddr[0]); end
        compared++; if (gReadyAt !== 14 || gRdata !== 32'hA1) begin mismatched++; $display("[TB] FAIL rstmid_rdata got %0d/%h want 14/000000a1", gReadyAt, gRdata); end
    endtask

    initial begin
        test_reset;
        test_miss_refill;
        test_hit;
        test_back_to_back;
        test_eviction;
        test_inv_with_fetch;
        test_inv_restart;
        test_reset_mid_refill;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
